// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES request arbiter and other shared engines.
//   arb_state_t : arbiter FSM states
//   AES_BLK_W   : AES block / key width (AES-128)
//   rr_pick()   : round-robin pick over up to RR_MAX requesters; returns the
//                 first set request scanning ptr, ptr+1, ... modulo n.
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;
    localparam int RR_MAX    = 8;

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
        rr_pick_t r;
        int       k;
        r = '0;
        // Scan from the farthest offset down so the nearest hit to ptr wins.
        for (int i = RR_MAX-1; i >= 0; i--) begin
            if (i < n) begin
                k = (int'(ptr) + i) % n;
                if (req[3'(k)]) begin
                    r.found = 1'b1;
                    r.idx   = 3'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : binary index of the grant
//   found : any request present
module aes_rr_arbiter import aes_arb_pkg::*; #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    rr_pick_t pick;
    logic     unused_idx;

    assign pick  = rr_pick(RR_MAX'(req), 3'(ptr), NUM_REQ);
    assign found = pick.found;
    assign idx   = pick.idx[IDX_W-1:0];
    // Upper index bits are always zero for small NUM_REQ.
    assign unused_idx = ^pick.idx;

    always_comb begin
        grant = '0;
        if (pick.found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 encrypt core among NUM_REQ requesters, round-robin.
// One job in flight: accept (IDLE) -> load pulse (LOAD) -> wait done (BUSY)
// -> return ciphertext to the owner under valid/ready (RESP).
// Optional feature macro: AES_ARB_TIMEOUT_EN adds a BUSY watchdog of MAX_WAIT
// cycles that aborts the job with resp_err=1, resp_data=0.
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   req_valid/ready         : per-requester job handshake (ready one-hot)
//   req_key/req_text        : packed per-requester key/plaintext, 128b each
//   resp_valid/ready        : per-requester result handshake (valid one-hot)
//   resp_data/resp_err      : shared ciphertext and abort flag
//   aes_ld/key/text_in      : core load interface
//   aes_done/text_out       : core completion and ciphertext
//   busy                    : FSM not idle
module aes_req_arbiter import aes_arb_pkg::*; #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_WAIT = 31,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_text,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [AES_BLK_W-1:0]         resp_data,
    output logic                         resp_err,
    output logic                         aes_ld,
    output logic [AES_BLK_W-1:0]         aes_key,
    output logic [AES_BLK_W-1:0]         aes_text_in,
    input  logic                         aes_done,
    input  logic [AES_BLK_W-1:0]         aes_text_out,
    output logic                         busy
);

    if (NUM_REQ < 2 || NUM_REQ > RR_MAX || MAX_WAIT < 1) begin : g_param_chk
        $error("aes_req_arbiter: NUM_REQ must be 2..8 and MAX_WAIT >= 1");
    end

    arb_state_t state;
    logic [IDX_W-1:0] rr_ptr, owner;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0] gnt_idx;
    logic gnt_found;

    logic [NUM_REQ-1:0][AES_BLK_W-1:0] key_arr, text_arr;
    assign key_arr  = req_key;
    assign text_arr = req_text;

    aes_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    // Accept is combinational; held off while reset is asserted so a
    // requester never sees a handshake that the reset then discards.
    assign req_ready = (rst && state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

`ifdef AES_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(MAX_WAIT + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign resp_err = 1'b0;
`endif

    // aes_key/aes_text_in double as the job registers: they are captured at
    // accept so they are already valid during the LOAD pulse, and they hold
    // until the next accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            aes_ld      <= 1'b0;
            aes_key     <= '0;
            aes_text_in <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            resp_err    <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    owner       <= gnt_idx;
                    aes_key     <= key_arr[gnt_idx];
                    aes_text_in <= text_arr[gnt_idx];
                    aes_ld      <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: begin
                    aes_ld <= 1'b0;
                    state  <= BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                BUSY: begin
                    if (aes_done) begin
                        resp_data  <= aes_text_out;
                        resp_valid <= NUM_REQ'(1) << owner;
                        state      <= RESP;
`ifdef AES_ARB_TIMEOUT_EN
                        resp_err   <= 1'b0;
                    end else if (wd_cnt == WD_W'(MAX_WAIT - 1)) begin
                        // Limit reached this cycle with no done: abort.
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= NUM_REQ'(1) << owner;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                RESP: if (resp_ready[owner]) begin
                    resp_valid <= '0;
                    rr_ptr     <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: random requesters, a behavioural
// AES core stand-in, a reference arbitration model and a response scoreboard.
module tb_aes_req_arbiter;

    localparam int N  = 4;
    localparam int MW = 31;
    localparam int W  = 128;
    localparam logic [W-1:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] FIPS_T = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_key = '0;
    logic [N*W-1:0] req_text = '0;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '0;
    logic [W-1:0]   resp_data;
    logic           resp_err;
    logic           aes_ld;
    logic [W-1:0]   aes_key;
    logic [W-1:0]   aes_text_in;
    logic           aes_done = 1'b0;
    logic [W-1:0]   aes_text_out = '0;
    logic           busy;

    aes_req_arbiter #(.NUM_REQ(N), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_text(req_text),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_done(aes_done), .aes_text_out(aes_text_out),
        .busy(busy)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Stand-in cipher: real FIPS-197 vector for its inputs, a keyed mix otherwise.
    function automatic logic [W-1:0] aes_model(input logic [W-1:0] k, input logic [W-1:0] t);
        if (k == FIPS_K && t == FIPS_T) return FIPS_C;
        return k ^ {t[63:0], t[127:64]} ^ 128'hc3a5_5a3c_0f1e_2d4b_9687_7869_5a4b_3c2d;
    endfunction

    // Stimulus knobs (percentages / latency range / modes)
    int p_req = 0, p_rereq = 0, p_drop = 0, p_rr = 100, spur = 0;
    int lat_min = 3, lat_max = 3;
    bit hang = 1'b0;

    typedef struct { int owner; logic [W-1:0] data; logic err; } exp_t;
    exp_t exp_q[$];

    // Reference arbitration model state
    int           m_rr = 0;
    bit           inflight = 1'b0;
    int           cur_owner = 0;
    bit           ld_due = 1'b0;
    bit           saw_ld = 1'b0;
    logic [W-1:0] ld_key, ld_text;
    logic [N-1:0] granted_last = '0;

    task automatic new_job(input int i);
        req_valid[i] = 1'b1;
        req_key[W*i +: W]  = {$urandom, $urandom, $urandom, $urandom};
        req_text[W*i +: W] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drv_sample();
        logic [N-1:0] exp_rdy;
        int g;
        @(negedge clk);
        if (!rst) begin
            inflight = 0; m_rr = 0; ld_due = 0; granted_last = '0;
            return;
        end
        exp_rdy = '0;
        g = -1;
        if (!inflight)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk_eq("req_ready", W'(req_ready), W'(exp_rdy));
        chk_eq("busy", W'(busy), W'(inflight));
        chk_eq("aes_ld", W'(aes_ld), W'(ld_due));
        if (ld_due) begin
            chk_eq("aes_key", aes_key, ld_key);
            chk_eq("aes_text_in", aes_text_in, ld_text);
            saw_ld = 1'b1;
        end
        ld_due = 1'b0;
        if (inflight && resp_valid[cur_owner] && resp_ready[cur_owner]) begin
            inflight = 1'b0;
            m_rr = (cur_owner + 1) % N;
        end
        if (g >= 0) begin
            exp_t e;
            inflight  = 1'b1;
            cur_owner = g;
            ld_due    = 1'b1;
            ld_key    = req_key[W*g +: W];
            ld_text   = req_text[W*g +: W];
            e.owner = g;
            e.err   = hang;
            e.data  = hang ? '0 : aes_model(ld_key, ld_text);
            exp_q.push_back(e);
        end
        granted_last = req_ready;
    endtask

    task automatic drv_drive();
        for (int i = 0; i < N; i++) begin
            if (granted_last[i]) begin
                if (int'($urandom % 100) < p_rereq) new_job(i); else req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
                if (int'($urandom % 100) < p_req) new_job(i);
            end else if (int'($urandom % 100) < p_drop) begin
                req_valid[i] = 1'b0;
            end
            resp_ready[i] = int'($urandom % 100) < p_rr;
        end
    endtask

    task automatic run_cycle();
        drv_sample();
        @(posedge clk); #1;
        drv_drive();
    endtask

    // Called aligned to posedge+1.
    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        inflight = 0; m_rr = 0; ld_due = 0; granted_last = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_req_ready", W'(req_ready), '0);
        chk_eq("rst_resp_valid", W'(resp_valid), '0);
        chk_eq("rst_resp_data", resp_data, '0);
        chk_eq("rst_resp_err", W'(resp_err), '0);
        chk_eq("rst_aes_ld", W'(aes_ld), '0);
        chk_eq("rst_aes_key", aes_key, '0);
        chk_eq("rst_aes_text_in", aes_text_in, '0);
        chk_eq("rst_busy", W'(busy), '0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        p_req = 0; p_rereq = 0; p_drop = 0; p_rr = 100;
        for (k = 0; k < 3000; k++) begin
            run_cycle();
            if (!inflight && req_valid == '0 && exp_q.size() == 0) break;
        end
        chk_eq("drain", W'(k < 3000), W'(1));
    endtask

    // Core stand-in: latches the job on aes_ld, answers after a latency,
    // and may raise spurious done pulses whenever it has no job.
    bit           c_pend = 1'b0, c_hang = 1'b0;
    int           c_cnt = 0;
    logic [W-1:0] c_key, c_text;
    int           exp_resp_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) c_pend = 1'b0;
        else if (aes_ld) begin
            c_pend = 1'b1; c_key = aes_key; c_text = aes_text_in; c_hang = hang;
            c_cnt = $urandom_range(lat_max, lat_min);
            if (hang) exp_resp_cyc = cyc + MW + 1;
        end
        @(posedge clk); #1;
        aes_done = 1'b0;
        if (c_pend && !c_hang) begin
            c_cnt--;
            if (c_cnt == 0) begin
                aes_done = 1'b1;
                aes_text_out = aes_model(c_key, c_text);
                c_pend = 1'b0;
                exp_resp_cyc = cyc + 1;
            end
        end else if (!c_pend && rst && int'($urandom % 100) < spur) begin
            aes_done = 1'b1;
            aes_text_out = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Response monitor / scoreboard
    bit           m_active = 1'b0;
    logic [N-1:0] m_v;
    logic [W-1:0] m_d;
    logic         m_e;
    exp_t         m_x;
    logic [N-1:0] m_oh;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_active = 1'b0;
        end else if (resp_valid != '0) begin
            if (!m_active) begin
                if (exp_q.size() == 0) chk_eq("resp_unexpected", W'(resp_valid), '0);
                else begin
                    m_x = exp_q.pop_front();
                    m_oh = '0;
                    m_oh[m_x.owner] = 1'b1;
                    chk_eq("resp_owner", W'(resp_valid), W'(m_oh));
                    chk_eq("resp_data", resp_data, m_x.data);
                    chk_eq("resp_err", W'(resp_err), W'(m_x.err));
                    chk_eq("resp_latency", W'(cyc), W'(exp_resp_cyc));
                end
                m_active = 1'b1;
                m_v = resp_valid; m_d = resp_data; m_e = resp_err;
            end else begin
                chk_eq("hold_valid", W'(resp_valid), W'(m_v));
                chk_eq("hold_data", resp_data, m_d);
                chk_eq("hold_err", W'(resp_err), W'(m_e));
            end
            if ((resp_valid & resp_ready) != '0) m_active = 1'b0;
        end else begin
            if (m_active) chk_eq("resp_dropped", W'(resp_valid), W'(m_v));
            m_active = 1'b0;
        end
    end

    initial begin
        @(posedge clk); #1;
        do_reset();

        // FIPS-197 single job
        p_rr = 100; resp_ready = '1; lat_min = 3; lat_max = 3;
        req_valid[0] = 1'b1;
        req_key[0 +: W] = FIPS_K;
        req_text[0 +: W] = FIPS_T;
        drain();

        // Contention from reset, requesters re-request immediately
        do_reset();
        for (int i = 0; i < N; i++) new_job(i);
        p_req = 0; p_rereq = 100; p_drop = 0; p_rr = 100; lat_min = 2; lat_max = 5;
        repeat (60) run_cycle();
        drain();

        // Backpressure with other requesters waiting
        p_rr = 0; p_req = 60; p_rereq = 0;
        repeat (30) run_cycle();
        drain();

        // Random traffic with spurious done pulses
        spur = 20; lat_min = 1; lat_max = 8;
        p_req = 30; p_rereq = 30; p_drop = 5; p_rr = 60;
        repeat (1500) run_cycle();
        drain();
        spur = 0;

        // Reset five cycles into BUSY
        lat_min = 20; lat_max = 20; saw_ld = 1'b0;
        new_job(2);
        for (int k = 0; k < 50 && !saw_ld; k++) run_cycle();
        chk_eq("ld_seen", W'(saw_ld), W'(1));
        repeat (4) run_cycle();
        do_reset();
        repeat (30) run_cycle();
        lat_min = 4; lat_max = 4;
        new_job(2);
        drain();

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog aborts, then round-robin continues
        hang = 1'b1;
        new_job(1); new_job(3);
        drain();
        hang = 1'b0;
        // Done on the limit cycle still gives a normal response
        lat_min = 31; lat_max = 31;
        new_job(0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
